// File: rtl/forward_scoreboard.sv
// Operand-forwarding select and load-use hazard unit backed by a shadow pipeline of destination records.
// Optional FWD_SCOREBOARD_STATS_EN adds saturating stall/forward event counters.
module forward_scoreboard #(
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int REG_W      = 5,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] rs1_ex,
    input  logic [REG_W-1:0] rs2_ex,
    input  logic             use_rs1_ex,
    input  logic             use_rs2_ex,
    output logic [SEL_W-1:0] forward_a,
    output logic [SEL_W-1:0] forward_b,
    output logic             stall_ex
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]      stall_count,
    output logic [31:0]      fwd_count
`endif
);

    logic [FWD_DEPTH:1] sh_vld;
    logic [FWD_DEPTH:1] sh_rw;
    logic [FWD_DEPTH:1] sh_ld;
    logic [REG_W-1:0]   sh_rd [1:FWD_DEPTH];

    logic [SEL_W-1:0] sel_a, sel_b;
    logic             ld_a, ld_b;
    logic             hz_a, hz_b;

    // Scan oldest to youngest so the smallest matching stage is left standing.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (use_rs1_ex && (rs1_ex != '0) && sh_vld[k] && sh_rw[k] && (sh_rd[k] == rs1_ex)) begin
                sel_a = SEL_W'(k);
                ld_a  = sh_ld[k];
            end
            if (use_rs2_ex && (rs2_ex != '0) && sh_vld[k] && sh_rw[k] && (sh_rd[k] == rs2_ex)) begin
                sel_b = SEL_W'(k);
                ld_b  = sh_ld[k];
            end
        end
        hz_a = ex_valid && ld_a && (sel_a != '0) && (int'(sel_a) < LOAD_STAGE);
        hz_b = ex_valid && ld_b && (sel_b != '0) && (int'(sel_b) < LOAD_STAGE);
    end

    // A hazarded operand gets no select; the older match is not a valid substitute.
    assign stall_ex  = ~reset & (hz_a | hz_b);
    assign forward_a = (reset || hz_a) ? '0 : sel_a;
    assign forward_b = (reset || hz_b) ? '0 : sel_b;

    // Shadow stage boundary: control bits, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_vld <= '0;
        end else if (advance) begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                sh_vld[k] <= sh_vld[k-1];
            end
            sh_vld[1] <= ex_valid & ~stall_ex;
        end
    end

    // Shadow stage boundary: record payload, meaningful only under its valid bit.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                sh_rd[k] <= sh_rd[k-1];
                sh_rw[k] <= sh_rw[k-1];
                sh_ld[k] <= sh_ld[k-1];
            end
            sh_rd[1] <= ex_rd;
            sh_rw[1] <= ex_regwrite;
            sh_ld[1] <= ex_is_load;
        end
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (advance && stall_ex)
                stall_count <= sat_inc(stall_count);
            if (advance && ex_valid && !stall_ex && ((forward_a != '0) || (forward_b != '0)))
                fwd_count <= sat_inc(fwd_count);
        end
    end
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: default build (depth 2) and a depth-4 / load-stage-3 build.
module tb_forward_scoreboard;

    typedef struct packed {
        logic       adv;
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
    } in_t;

    typedef struct {
        int         w;
        logic [2:0] fa;
        logic [2:0] fb;
        logic       st;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  din [2];
    exp_t q [$];
    int   checks = 0;
    int   passed = 0;
    int   step_id = 0;

    logic [1:0] fa0, fb0;
    logic [2:0] fa1, fb1;
    logic       st0, st1;
`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] sc0, fc0, sc1, fc1;
`endif

    always #5 clk = ~clk;

    forward_scoreboard u0 (
        .clk(clk), .reset(rst), .advance(din[0].adv), .ex_valid(din[0].v),
        .ex_rd(din[0].rd), .ex_regwrite(din[0].rw), .ex_is_load(din[0].ld),
        .rs1_ex(din[0].rs1), .rs2_ex(din[0].rs2),
        .use_rs1_ex(din[0].u1), .use_rs2_ex(din[0].u2),
        .forward_a(fa0), .forward_b(fb0), .stall_ex(st0)
`ifdef FWD_SCOREBOARD_STATS_EN
        , .stall_count(sc0), .fwd_count(fc0)
`endif
    );

    forward_scoreboard #(.FWD_DEPTH(4), .LOAD_STAGE(3)) u1 (
        .clk(clk), .reset(rst), .advance(din[1].adv), .ex_valid(din[1].v),
        .ex_rd(din[1].rd), .ex_regwrite(din[1].rw), .ex_is_load(din[1].ld),
        .rs1_ex(din[1].rs1), .rs2_ex(din[1].rs2),
        .use_rs1_ex(din[1].u1), .use_rs2_ex(din[1].u2),
        .forward_a(fa1), .forward_b(fb1), .stall_ex(st1)
`ifdef FWD_SCOREBOARD_STATS_EN
        , .stall_count(sc1), .fwd_count(fc1)
`endif
    );

    // Monitor: outputs are combinational, so each driven cycle presents one response.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [2:0] afa, afb;
            logic       ast;
            e   = q.pop_front();
            afa = (e.w == 0) ? {1'b0, fa0} : fa1;
            afb = (e.w == 0) ? {1'b0, fb0} : fb1;
            ast = (e.w == 0) ? st0 : st1;
            checks++;
            if (afa === e.fa && afb === e.fb && ast === e.st)
                passed++;
            else
                $display("FAIL step%0d dut%0d: got fa=%0d fb=%0d stall=%0b, expected fa=%0d fb=%0d stall=%0b",
                         e.id, e.w, afa, afb, ast, e.fa, e.fb, e.st);
        end
    end

    task automatic drive(input int w, input logic r, input logic adv, input logic v,
                         input logic [4:0] rd, input logic rw, input logic ld,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [2:0] efa, input logic [2:0] efb, input logic est);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        din[w]    = {adv, v, rd, rw, ld, rs1, rs2, u1, u2};
        din[1-w]  = '0;
        step_id++;
        e.w = w; e.fa = efa; e.fb = efb; e.st = est; e.id = step_id;
        q.push_back(e);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    initial begin
        din[0] = '0;
        din[1] = '0;
        // reset, with inputs that would otherwise match
        drive(0, 1, 1, 1,  5, 1, 0,  5,  5, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0, 0);
        // ALU forwarding from stage 1 then stage 2
        drive(0, 0, 1, 1,  5, 1, 0,  0,  0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1,  6, 1, 0,  5,  0, 1, 0, 1, 0, 0);
        drive(0, 0, 1, 1,  8, 1, 0,  5,  0, 1, 0, 2, 0, 0);
        // load-use on rs2: one stall, then forward from stage 2
        drive(0, 0, 1, 1,  7, 1, 1,  0,  0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 10, 1, 0,  0,  7, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 1, 10, 1, 0,  0,  7, 0, 1, 0, 2, 0);
        // x3 in both stages: youngest wins; x0 never matches
        drive(0, 0, 1, 1,  3, 1, 0,  0,  0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1,  3, 1, 0,  0,  0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1,  0, 1, 0,  3,  3, 1, 1, 1, 1, 0);
        drive(0, 0, 1, 1, 11, 0, 0,  0,  3, 1, 1, 0, 2, 0);
        // regwrite=0 producer and unused operand do not forward
        drive(0, 0, 1, 1, 12, 1, 0, 11,  3, 1, 0, 0, 0, 0);
        // stall held with advance=0; unaffected operand still forwards
        drive(0, 0, 1, 1, 13, 1, 1,  0,  0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 14, 1, 0, 13, 12, 1, 1, 0, 2, 1);
        drive(0, 0, 0, 1, 14, 1, 0, 13, 12, 1, 1, 0, 2, 1);
        drive(0, 0, 1, 1, 14, 1, 0, 13, 12, 1, 1, 0, 2, 1);
        drive(0, 0, 1, 1, 14, 1, 0, 13, 12, 1, 1, 2, 0, 0);
        // reset during an active stall
        drive(0, 0, 1, 1,  7, 1, 1,  0,  0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1,  0, 0, 0, 14,  7, 1, 1, 2, 0, 1);
        drive(0, 1, 1, 1,  0, 0, 0, 14,  7, 1, 1, 0, 0, 0);
        drive(0, 0, 1, 1,  0, 0, 0, 14,  7, 1, 1, 0, 0, 0);
        // fresh load-use then forward sequence (also feeds the counters)
        drive(0, 0, 1, 1,  7, 1, 1,  0,  0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1,  0, 0, 0,  0,  7, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 1,  0, 0, 0,  0,  7, 0, 1, 0, 2, 0);
        drive(0, 0, 1, 1,  5, 1, 0,  0,  0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1,  0, 0, 0,  5,  0, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0, 0);
`ifdef FWD_SCOREBOARD_STATS_EN
        @(negedge clk);
        check32("stall_count", sc0, 32'd1);
        check32("fwd_count", fc0, 32'd2);
`endif
        // depth 4, load stage 3: two advancing stall cycles, three held
        drive(1, 0, 1, 1,  9, 1, 1,  0,  0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 1,  0, 0, 0,  9,  0, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 1,  0, 0, 0,  9,  0, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 1,  0, 0, 0,  9,  0, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 1,  0, 0, 0,  9,  0, 1, 0, 0, 0, 1);
        drive(1, 0, 1, 1,  0, 0, 0,  9,  0, 1, 0, 0, 0, 1);
        drive(1, 0, 1, 1,  0, 0, 0,  9,  0, 1, 0, 3, 0, 0);
        drive(1, 0, 1, 1,  0, 0, 0,  9,  0, 1, 0, 4, 0, 0);
        // saturation of the stall counter
        drive(0, 0, 1, 1, 20, 1, 1,  0,  0, 0, 0, 0, 0, 0);
`ifdef FWD_SCOREBOARD_STATS_EN
        force u0.stall_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release u0.stall_count;
`endif
        drive(0, 0, 1, 1,  0, 0, 0, 20,  0, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0, 0);
`ifdef FWD_SCOREBOARD_STATS_EN
        @(negedge clk);
        check32("stall_count_sat", sc0, 32'hFFFF_FFFF);
`endif
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d responses unchecked, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised operand-forwarding and load-use hazard unit for the RISC-V pipeline. It keeps an internal shadow pipeline of destination-register records for the instructions in the FWD_DEPTH stages after EX. Each cycle it selects, per EX source operand, the youngest in-flight producer, or the register file. When the youngest producer is a load whose data is not yet available, it raises a stall and injects a bubble into its shadow pipeline.

## Interface
- FWD_DEPTH, 2, number of tracked post-EX stages (1..7); stage 1 = MEM, stage 2 = WB in the 5-stage build
- LOAD_STAGE, 2, first stage index at which load data is forwardable (1..FWD_DEPTH)
- REG_W, 5, register-index width
- SEL_W, $clog2(FWD_DEPTH+1), derived; width of forward selects
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- advance  in  1  pipeline moves this cycle; when 0, all shadow state holds
- ex_valid  in  1  EX holds a live instruction
- ex_rd  in  REG_W  EX destination register
- ex_regwrite  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- rs1_ex, rs2_ex  in  REG_W  EX source registers
- use_rs1_ex, use_rs2_ex  in  1  EX instruction reads rs1 / rs2
- forward_a, forward_b  out  SEL_W  0 = register file, k = value from stage k
- stall_ex  out  1  load-use hazard; hold EX, bubble into stage 1

## Operation
- Shadow entry per stage k (1..FWD_DEPTH): valid, rd, regwrite, is_load.
- Match at stage k for operand X: use_X, rsX_ex != 0, valid_k, regwrite_k, rd_k == rsX_ex.
- Priority: smallest matching k wins. forward_X = k; 0 if no match.
- Hazard: ex_valid and the winning match for a used operand has is_load with k < LOAD_STAGE. stall_ex = 1, and the affected forward select is driven 0. There is no fallback to an older match.
- Stores use forward_b for store data; there is no separate store path.
- On clk edge with advance = 1: stage k+1 <= stage k. Stage 1 <= {ex_valid & ~stall_ex, ex_rd, ex_regwrite, ex_is_load}. A stall therefore inserts an invalid bubble.
- advance = 0: no entry changes. Outputs still track current inputs and state.
- ex_valid = 0: forward selects and stall_ex are computed normally, but stall_ex is gated to 0.
- The entry shifted out of stage FWD_DEPTH is discarded.
- x0 never matches, so writes to rd = 0 are never forwarded.

## Timing
- forward_a, forward_b, stall_ex: combinational from inputs and current shadow state, with zero-cycle latency.
- Shadow update: one cycle. A producer in EX at cycle n is visible as stage 1 at cycle n+1 if advance was 1.
- Reset: all valid bits cleared on the clk edge with reset = 1. While reset is high, all outputs are forced to 0 regardless of inputs.
- Reset mid-stall: the stall drops in the reset cycle, and the shadow pipeline is empty afterwards.
- Simultaneous stall_ex and advance = 0: nothing shifts. Stall persists until advance = 1 moves the load to LOAD_STAGE.
- Default parameters give a 1-cycle load-use penalty. In general the penalty is LOAD_STAGE - k cycles of advance.

## Configuration
- FWD_SCOREBOARD_STATS_EN defined adds two ports:
  - stall_count  out  32: increments on each clk edge with advance & stall_ex.
  - fwd_count  out  32: increments on each clk edge with advance & ex_valid & ~stall_ex & (forward_a != 0 | forward_b != 0).
- Both counters saturate at 32'hFFFF_FFFF and are cleared by reset.
- Undefined: the ports and counters are absent. Forwarding behaviour is identical in both builds.

## Test plan
- Defaults. Enter add x5 (regwrite), advance 1 cycle. Next EX uses rs1 = x5 -> forward_a = 1, stall_ex = 0. Advance again with an unrelated EX -> forward_a = 2.
- Defaults. Enter lw x7, advance. EX uses rs2 = x7 -> stall_ex = 1, forward_b = 0. Advance -> bubble in stage 1, lw in stage 2, stall_ex = 0, forward_b = 2.
- x3 is in both stage 1 (add) and stage 2 (sub). EX reads rs1 = rs2 = x3 -> forward_a = forward_b = 1. Write to rd = x0 with rs1 = x0 -> forward_a = 0.
- FWD_DEPTH = 4, LOAD_STAGE = 3. Load to x9, EX reads x9 -> stall for exactly 2 advancing cycles, then forward_a = 3. Hold advance = 0 for 3 cycles mid-stall -> stall persists and state is unchanged.
- Assert reset while a lw x7 hazard is active -> stall_ex = 0 and forwards = 0 during reset. After release, EX reading x7 -> forward = 0.
- With FWD_SCOREBOARD_STATS_EN: run the load-use test -> stall_count = 1. Run the forward test -> fwd_count = 2. Preload the counter at 32'hFFFF_FFFF via force and apply a stall -> value stays at 32'hFFFF_FFFF.
